// File: rtl/accel_bus_pkg.sv
// Shared definitions for the accelerator bus arbiter: bus widths, FSM
// encoding, default error read data and accelerator register addresses.
package accel_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Returned to the master when the slave never answers.
  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  // Matmul accelerator register map.
  localparam logic [ADDR_W-1:0] ACC_OPERAND_ADDR = 32'h0100_3000;
  localparam logic [ADDR_W-1:0] ACC_RESULT_ADDR  = 32'h0100_3004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/accel_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Combinational pick from the request vector and the last-grant pointer.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/accel_bus_arbiter.sv
// Two-master, one-slave arbiter for the native mem_valid/mem_ready bus in
// front of the matmul accelerator. One transaction in flight, round-robin
// grant, response timeout for unmapped addresses, and a release cycle so a
// slave that holds mem_ready until mem_valid drops is counted only once.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no transaction; pick a requester and capture its request
//   ST_BUSY    | s_mem_valid high, waiting for slave ready or timeout
//   ST_RELEASE | one cycle: s_mem_valid low, ready pulse to granted master
module accel_bus_arbiter
  import accel_bus_pkg::*;
#(
  parameter int                TIMEOUT   = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_mem_valid,
  input  logic [ADDR_W-1:0] m0_mem_addr,
  input  logic [DATA_W-1:0] m0_mem_wdata,
  input  logic [STRB_W-1:0] m0_mem_wstrb,
  output logic              m0_mem_ready,
  output logic [DATA_W-1:0] m0_mem_rdata,

  input  logic              m1_mem_valid,
  input  logic [ADDR_W-1:0] m1_mem_addr,
  input  logic [DATA_W-1:0] m1_mem_wdata,
  input  logic [STRB_W-1:0] m1_mem_wstrb,
  output logic              m1_mem_ready,
  output logic [DATA_W-1:0] m1_mem_rdata,

  output logic              s_mem_valid,
  output logic [ADDR_W-1:0] s_mem_addr,
  output logic [DATA_W-1:0] s_mem_wdata,
  output logic [STRB_W-1:0] s_mem_wstrb,
  input  logic              s_mem_ready,
  input  logic [DATA_W-1:0] s_mem_rdata,

  output logic              timeout_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [CNT_W-1:0]  count;
  logic              grant;
  logic              last;
  logic              pick_valid;
  logic              pick_idx;
  logic              do_grant;
  logic              resp_slave;
  logic              resp_timeout;
  logic              resp_any;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .req       ({m1_mem_valid, m0_mem_valid}),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle decisions; the slave response wins over a
  // timeout landing on the same edge. Slave ready outside BUSY is stale.
  always_comb begin
    state_next   = state;
    do_grant     = 1'b0;
    resp_slave   = 1'b0;
    resp_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          do_grant   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_mem_ready) begin
          resp_slave = 1'b1;
          state_next = ST_RELEASE;
        end else if (count == CNT_LAST) begin
          resp_timeout = 1'b1;
          state_next   = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Response payload: error word on timeout, slave data on reads, 0 on writes.
  always_comb begin
    resp_any  = resp_slave | resp_timeout;
    resp_data = '0;
    if (resp_timeout) begin
      resp_data = ERR_RDATA;
    end else if (resp_slave && (s_mem_wstrb == '0)) begin
      resp_data = s_mem_rdata;
    end
  end

  // Capture, timeout counter, response pulses and sticky error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_mem_valid  <= 1'b0;
      s_mem_addr   <= '0;
      s_mem_wdata  <= '0;
      s_mem_wstrb  <= '0;
      m0_mem_ready <= 1'b0;
      m0_mem_rdata <= '0;
      m1_mem_ready <= 1'b0;
      m1_mem_rdata <= '0;
      timeout_err  <= 1'b0;
      count        <= '0;
      grant        <= 1'b0;
      last         <= 1'b1;
    end else begin
      s_mem_valid  <= (state_next == ST_BUSY);
      m0_mem_ready <= resp_any && !grant;
      m1_mem_ready <= resp_any && grant;
      if (resp_any && !grant) begin
        m0_mem_rdata <= resp_data;
      end
      if (resp_any && grant) begin
        m1_mem_rdata <= resp_data;
      end
      if (resp_timeout) begin
        timeout_err <= 1'b1;
      end
      if (do_grant) begin
        s_mem_addr  <= pick_idx ? m1_mem_addr  : m0_mem_addr;
        s_mem_wdata <= pick_idx ? m1_mem_wdata : m0_mem_wdata;
        s_mem_wstrb <= pick_idx ? m1_mem_wstrb : m0_mem_wstrb;
        grant       <= pick_idx;
        last        <= pick_idx;
        count       <= '0;
      end else if ((state == ST_BUSY) && !resp_any) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accel_bus_arbiter.sv
// Self-checking bench for accel_bus_arbiter: directed scenarios plus a
// randomized two-master phase checked against a transaction-level model of
// the accelerator register and the round-robin fairness rule.
module tb_accel_bus_arbiter;
  import accel_bus_pkg::*;

  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_mem_valid = 1'b0, m1_mem_valid = 1'b0;
  logic [31:0] m0_mem_addr = '0, m1_mem_addr = '0;
  logic [31:0] m0_mem_wdata = '0, m1_mem_wdata = '0;
  logic [3:0]  m0_mem_wstrb = '0, m1_mem_wstrb = '0;
  logic        m0_mem_ready, m1_mem_ready;
  logic [31:0] m0_mem_rdata, m1_mem_rdata;
  logic        s_mem_valid;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  logic        s_mem_ready;
  logic [31:0] s_mem_rdata;
  logic        timeout_err;

  int n_total = 0;
  int n_bad   = 0;

  accel_bus_arbiter #(.TIMEOUT(TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m0_mem_valid (m0_mem_valid),
    .m0_mem_addr  (m0_mem_addr),
    .m0_mem_wdata (m0_mem_wdata),
    .m0_mem_wstrb (m0_mem_wstrb),
    .m0_mem_ready (m0_mem_ready),
    .m0_mem_rdata (m0_mem_rdata),
    .m1_mem_valid (m1_mem_valid),
    .m1_mem_addr  (m1_mem_addr),
    .m1_mem_wdata (m1_mem_wdata),
    .m1_mem_wstrb (m1_mem_wstrb),
    .m1_mem_ready (m1_mem_ready),
    .m1_mem_rdata (m1_mem_rdata),
    .s_mem_valid  (s_mem_valid),
    .s_mem_addr   (s_mem_addr),
    .s_mem_wdata  (s_mem_wdata),
    .s_mem_wstrb  (s_mem_wstrb),
    .s_mem_ready  (s_mem_ready),
    .s_mem_rdata  (s_mem_rdata),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave: operand write stores, result read returns stored+1, ready held
  // for hold_extra cycles after valid drops, other addresses never answer.
  logic [31:0] slv_reg = '0;
  int          hold_extra = 0;
  int          hold_cnt = 0;
  logic        slv_mapped;
  assign slv_mapped  = (s_mem_addr == ACC_OPERAND_ADDR) || (s_mem_addr == ACC_RESULT_ADDR);
  assign s_mem_ready = (s_mem_valid && slv_mapped) || (hold_cnt > 0);
  assign s_mem_rdata = (s_mem_addr == ACC_RESULT_ADDR) ? slv_reg + 32'd1 : 32'd0;

  always @(posedge clk) begin
    if (s_mem_valid && slv_mapped) begin
      hold_cnt <= hold_extra;
      if ((s_mem_wstrb != 4'd0) && (s_mem_addr == ACC_OPERAND_ADDR)) slv_reg <= s_mem_wdata;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
    end
  end

  // Ready-pulse monitor: single-cycle, only to a requesting master, never both.
  int   pulses[2] = '{0, 0};
  logic prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (m0_mem_ready) begin
        check_val("m0_pulse_len", prev0, 1'b0);
        check_val("m0_ready_wo_req", m0_mem_valid, 1'b1);
        check_val("ready_both", m1_mem_ready, 1'b0);
        pulses[0]++;
      end
      if (m1_mem_ready) begin
        check_val("m1_pulse_len", prev1, 1'b0);
        check_val("m1_ready_wo_req", m1_mem_valid, 1'b1);
        pulses[1]++;
      end
      prev0 = m0_mem_ready;
      prev1 = m1_mem_ready;
    end
  end

  // Transaction-level model state.
  logic [31:0] ref_reg = '0;
  int          done_cnt[2] = '{0, 0};
  int          order_q[$];

  task automatic drive(input int m, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (m == 0) begin
      m0_mem_valid = v; m0_mem_addr = a; m0_mem_wdata = d; m0_mem_wstrb = s;
    end else begin
      m1_mem_valid = v; m1_mem_addr = a; m1_mem_wdata = d; m1_mem_wstrb = s;
    end
  endtask

  // One master transaction: raise valid, wait for ready (bounded), check the
  // response against the model, drop valid on the edge ending the pulse.
  task automatic mreq(input int m, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
    int          base_other;
    bit          got;
    logic [31:0] exp;
    base_other = done_cnt[1-m];
    drive(m, 1'b1, a, d, s);
    lat = 0;
    got = 0;
    rd  = '0;
    while (!got && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if ((m == 0) ? m0_mem_ready : m1_mem_ready) begin
        got = 1;
        rd  = (m == 0) ? m0_mem_rdata : m1_mem_rdata;
      end
    end
    if (!got) begin
      check_val($sformatf("m%0d_no_response", m), 1'b0, 1'b1);
    end else begin
      if (a == ACC_OPERAND_ADDR || a == ACC_RESULT_ADDR) begin
        if (s != 4'd0)                exp = 32'd0;
        else if (a == ACC_RESULT_ADDR) exp = ref_reg + 32'd1;
        else                          exp = 32'd0;
      end else begin
        exp = 32'hDEAD_BEEF;
        check_val($sformatf("m%0d_terr_set", m), timeout_err, 1'b1);
      end
      check_val($sformatf("m%0d_rdata a=%0h", m, a), rd, exp);
      check_val($sformatf("m%0d_fair", m), (done_cnt[1-m] - base_other) <= 1, 1'b1);
      if (a == ACC_OPERAND_ADDR && s != 4'd0) ref_reg = d;
      done_cnt[m]++;
      order_q.push_back(m);
    end
    @(posedge clk); #1;
    drive(m, 1'b0, a, d, s);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rand_master(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      int          r;
      int          lat;
      logic [31:0] a, d, rd;
      logic [3:0]  s;
      r = $urandom_range(0, 19);
      d = $urandom;
      if (r == 0)      begin a = 32'h0200_0000 + 32'($urandom_range(0, 255)); s = 4'd0; end
      else if (r <= 8) begin a = ACC_OPERAND_ADDR; s = 4'($urandom_range(1, 15)); end
      else if (r <= 16) begin a = ACC_RESULT_ADDR; s = 4'd0; end
      else             begin a = ACC_OPERAND_ADDR; s = 4'd0; end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      mreq(m, a, d, s, rd, lat);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          p0, p1;
    logic [71:0] m0_fields;
    bit          m0_done;

    do_reset();
    check_val("rst_s_valid", s_mem_valid, 1'b0);
    check_val("rst_m0_ready", m0_mem_ready, 1'b0);
    check_val("rst_m1_ready", m1_mem_ready, 1'b0);
    check_val("rst_terr", timeout_err, 1'b0);
    check_val("rst_s_addr", s_mem_addr, 32'd0);

    // 1: m0 write then read of the accelerator result.
    mreq(0, ACC_OPERAND_ADDR, 32'd5, 4'hF, rd, lat);
    check_val("t1_wr_lat", lat, 2);
    mreq(0, ACC_RESULT_ADDR, 32'd0, 4'd0, rd, lat);
    check_val("t1_rd_data", rd, 32'd6);
    check_val("t1_rd_lat", lat, 2);
    check_val("t1_m0_pulses", pulses[0], 2);
    check_val("t1_m1_pulses", pulses[1], 0);
    check_val("t1_terr", timeout_err, 1'b0);

    // 2: simultaneous requests after reset alternate starting with m0.
    do_reset();
    order_q.delete();
    fork
      begin
        logic [31:0] r0; int l0;
        for (int i = 0; i < 2; i++) mreq(0, ACC_OPERAND_ADDR, 32'h100 + 32'(i), 4'hF, r0, l0);
      end
      begin
        logic [31:0] r1; int l1;
        for (int i = 0; i < 2; i++) mreq(1, ACC_RESULT_ADDR, 32'd0, 4'd0, r1, l1);
      end
    join
    check_val("t2_order_len", order_q.size(), 4);
    for (int i = 0; i < order_q.size() && i < 4; i++)
      check_val($sformatf("t2_order_%0d", i), order_q[i], i % 2);

    // 3: unmapped read times out with the error word and a sticky flag.
    mreq(1, 32'h0200_0000, 32'd0, 4'd0, rd, lat);
    check_val("t3_lat", lat, TMO + 1);
    check_val("t3_rdata", rd, 32'hDEAD_BEEF);
    check_val("t3_terr", timeout_err, 1'b1);

    // 4: slave holds ready 5 cycles past valid; one pulse per transaction.
    hold_extra = 5;
    p0 = pulses[0];
    p1 = pulses[1];
    fork
      begin logic [31:0] r0; int l0; mreq(0, ACC_OPERAND_ADDR, 32'h77, 4'hF, r0, l0); end
      begin logic [31:0] r1; int l1; mreq(1, ACC_RESULT_ADDR, 32'd0, 4'd0, r1, l1); end
    join
    repeat (8) begin @(posedge clk); #1; end
    check_val("t4_m0_pulses", pulses[0] - p0, 1);
    check_val("t4_m1_pulses", pulses[1] - p1, 1);
    check_val("t4_s_valid_idle", s_mem_valid, 1'b0);
    check_val("t4_terr_sticky", timeout_err, 1'b1);
    hold_extra = 0;

    // 5: reset in the middle of a BUSY transaction.
    p1 = pulses[1];
    drive(1, 1'b1, 32'h0200_0040, 32'd0, 4'd0);
    repeat (5) @(posedge clk);
    #3;
    check_val("t5_busy_before", s_mem_valid, 1'b1);
    resetn = 1'b0;
    #1;
    check_val("t5_s_valid_drop", s_mem_valid, 1'b0);
    check_val("t5_m1_ready", m1_mem_ready, 1'b0);
    drive(1, 1'b0, 32'h0200_0040, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_val("t5_idle_s_valid", s_mem_valid, 1'b0);
    check_val("t5_terr_clr", timeout_err, 1'b0);
    check_val("t5_no_pulse", pulses[1] - p1, 0);
    mreq(1, ACC_RESULT_ADDR, 32'd0, 4'd0, rd, lat);
    check_val("t5_after_rd", rd, ref_reg + 32'd1);

    // 6: captured request stays stable while the waiting master toggles.
    m0_fields = {32'h0200_0010, 32'hA5A5_5A5A, 4'hF};
    m0_done   = 0;
    drive(1, 1'b1, $urandom, $urandom, 4'($urandom));
    fork
      begin
        logic [31:0] r0; int l0;
        mreq(0, 32'h0200_0010, 32'hA5A5_5A5A, 4'hF, r0, l0);
        m0_done = 1;
      end
      begin
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (m0_done) break;
          if (s_mem_valid) check_val("t6_s_stable", {s_mem_addr, s_mem_wdata, s_mem_wstrb}, m0_fields);
          drive(1, 1'b1, $urandom, $urandom, 4'($urandom));
        end
      end
    join
    mreq(1, ACC_RESULT_ADDR, 32'd0, 4'd0, rd, lat);
    check_val("t6_m1_rd", rd, ref_reg + 32'd1);

    // Randomized two-master traffic against the model.
    for (int round = 0; round < 2; round++) begin
      fork
        rand_master(0, 10);
        rand_master(1, 10);
      join
    end
    repeat (4) begin @(posedge clk); #1; end
    check_val("end_m0_pulses", pulses[0], done_cnt[0]);
    check_val("end_m1_pulses", pulses[1], done_cnt[1]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
